// File: rtl/ahb_apb_bridge_ctrl.sv
// AHB-to-APB bridge controller: pipelines the AHB address phase and
// sequences single-wait-free SETUP/ENABLE accesses on the APB side.
module ahb_apb_bridge_ctrl (
    input  logic        Hclk,
    input  logic        Hreset,
    input  logic        Hwrite,
    input  logic        Hreadyin,
    input  logic [1:0]  Htrans,
    input  logic [31:0] Haddr,
    input  logic [31:0] Hwdata,
    input  logic [31:0] Prdata,
    output logic        Hreadyout,
    output logic [31:0] Hrdata,
    output logic [1:0]  Hresp,
    output logic [31:0] Paddr,
    output logic [31:0] Pwdata,
    output logic [2:0]  Pselx,
    output logic        Pwrite,
    output logic        Penable
);

    typedef enum logic [2:0] {
        IDLE,
        WWAIT,
        READ,
        WRITE,
        WRITEP,
        RENABLE,
        WENABLE,
        WENABLEP
    } state_e;

    state_e state_q, state_d;

    logic [31:0] haddr1_q, haddr2_q, hwdata1_q;
    logic        hwrite_reg_q, hwrite_reg1_q;

    logic [31:0] paddr_q, pwdata_q;
    logic [2:0]  psel_q;
    logic        pwrite_q, penable_q, hready_q;

    logic        valid;
    logic [31:0] waddr;
    logic        pipe_unused;

    function automatic logic [2:0] sel_decode(input logic [31:0] a);
        logic [2:0] s;
        unique case (a[31:26])
            6'b100000: s = 3'b001;
            6'b100001: s = 3'b010;
            6'b100010: s = 3'b100;
            default:   s = 3'b000;
        endcase
        return s;
    endfunction

    assign valid = Hreadyin && Htrans[1] &&
                   (Haddr >= 32'h8000_0000) &&
                   (Haddr <  32'h8C00_0000);

    // Pipelined writes take the older address once the bridge is streaming.
    assign waddr = (state_q == WENABLEP) ? haddr2_q : haddr1_q;

    assign pipe_unused = ^{hwdata1_q, hwrite_reg1_q};

    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            haddr1_q      <= '0;
            haddr2_q      <= '0;
            hwdata1_q     <= '0;
            hwrite_reg_q  <= 1'b0;
            hwrite_reg1_q <= 1'b0;
        end else begin
            if (Hreadyin) begin
                haddr1_q     <= Haddr;
                hwrite_reg_q <= Hwrite;
                hwdata1_q    <= Hwdata;
            end
            haddr2_q      <= haddr1_q;
            hwrite_reg1_q <= hwrite_reg_q;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, RENABLE, WENABLE: begin
                if (valid) state_d = Hwrite ? WWAIT : READ;
                else       state_d = IDLE;
            end
            WWAIT:    state_d = valid ? WRITEP : WRITE;
            READ:     state_d = RENABLE;
            WRITE:    state_d = valid ? WENABLEP : WENABLE;
            WRITEP:   state_d = WENABLEP;
            WENABLEP: begin
                if (!hwrite_reg_q) state_d = READ;
                else               state_d = valid ? WRITEP : WRITE;
            end
            default:  state_d = IDLE;
        endcase
    end

    // Outputs are loaded from the state being entered.
    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            state_q   <= IDLE;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            psel_q    <= 3'b000;
            pwrite_q  <= 1'b0;
            penable_q <= 1'b0;
            hready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            hready_q <= !(state_d inside {READ, WRITEP, WENABLEP});
            unique case (state_d)
                IDLE, WWAIT: begin
                    psel_q    <= 3'b000;
                    pwrite_q  <= 1'b0;
                    penable_q <= 1'b0;
                end
                READ: begin
                    paddr_q   <= Haddr;
                    psel_q    <= sel_decode(Haddr);
                    pwrite_q  <= 1'b0;
                    penable_q <= 1'b0;
                end
                WRITE, WRITEP: begin
                    paddr_q   <= waddr;
                    pwdata_q  <= Hwdata;
                    psel_q    <= sel_decode(waddr);
                    pwrite_q  <= 1'b1;
                    penable_q <= 1'b0;
                end
                default: begin
                    penable_q <= 1'b1;
                end
            endcase
        end
    end

    assign Paddr     = paddr_q;
    assign Pwdata    = pwdata_q;
    assign Pselx     = psel_q;
    assign Pwrite    = pwrite_q;
    assign Penable   = penable_q;
    assign Hreadyout = hready_q;
    assign Hrdata    = Prdata;
    assign Hresp     = 2'b00;

endmodule
